// File: rtl/elc3_mem_pkg.sv
// elc3_mem_pkg -- shared definitions for the SRAM arbiter slice.
//   arb_state_t           : arbiter FSM state encoding
//   PORT_CPU / PORT_VID   : requester index used for grant and pointer
//   ACCESS_CYCLES_DEFAULT : default strobe width in clocks
//   CNT_W                 : access down-counter width (covers 1..15)
package elc3_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_VID = 1'b1;

  localparam int ACCESS_CYCLES_DEFAULT = 2;
  localparam int CNT_W                 = 4;

endpackage

// File: rtl/arb_picker.sv
// arb_picker -- combinational two-way grant selection.
// Ports:
//   cpu_req, vid_req : request lines
//   last_grant       : port granted most recently; on a tie the other port wins
//   grant            : winning port index (PORT_CPU / PORT_VID)
//   grant_valid      : at least one request present
// Tying last_grant to PORT_VID gives fixed CPU priority.
module arb_picker
  import elc3_mem_pkg::*;
(
  input  logic cpu_req,
  input  logic vid_req,
  input  logic last_grant,
  output logic grant,
  output logic grant_valid
);

  always_comb begin
    grant_valid = cpu_req | vid_req;
    grant       = PORT_CPU;
    if (cpu_req && vid_req) begin
      grant = (last_grant == PORT_CPU) ? PORT_VID : PORT_CPU;
    end else if (vid_req) begin
      grant = PORT_VID;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter -- two-port (CPU, video/DMA) arbiter for an asynchronous SRAM.
// One transaction at a time: IDLE -> SETUP -> ACCESS (ACCESS_CYCLES clocks) -> DONE.
// Ports:
//   Clk, Reset                  : clock, synchronous active-high reset
//   Cpu_* / Vid_*               : requester interfaces (Req held until Ack)
//   Busy                        : FSM not in IDLE
//   SRAM_*_N                    : active-low SRAM strobes
//   SRAM_ADDR, SRAM_DQ_Out/OE   : address, write data and its output enable
//   SRAM_DQ_In                  : read data from the SRAM pins
// Build option: define SRAM_ARB_RR_EN for round-robin on simultaneous requests;
// without it the CPU always wins and no pointer register exists.
//
// state  | meaning
// IDLE   | sample requests, latch winner's command
// SETUP  | CE/LB/UB low, address (and write data) set up
// ACCESS | OE or WE low for ACCESS_CYCLES clocks, read captured on last one
// DONE   | strobes released, Ack pulse to granted port
module sram_arbiter
  import elc3_mem_pkg::*;
#(
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Cpu_Req,
  input  logic        Cpu_R_W,
  input  logic [15:0] Cpu_Addr,
  input  logic [15:0] Cpu_WData,
  output logic        Cpu_Ack,
  output logic [15:0] Cpu_RData,
  input  logic        Vid_Req,
  input  logic        Vid_R_W,
  input  logic [15:0] Vid_Addr,
  input  logic [15:0] Vid_WData,
  output logic        Vid_Ack,
  output logic [15:0] Vid_RData,
  output logic        Busy,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N,
  output logic [19:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_Out,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_In
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        grant_q;
  logic        rw_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] cpu_rdata_q;
  logic [15:0] vid_rdata_q;

  logic pick_grant;
  logic pick_valid;
  logic last_grant;
  logic latch_en;
  logic capture_en;
  logic ack_en;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q;

  // Reset to VID so the first tie goes to the CPU.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_grant_q <= PORT_VID;
    end else if (latch_en) begin
      last_grant_q <= pick_grant;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = PORT_VID;
`endif

  arb_picker u_picker (
    .cpu_req     (Cpu_Req),
    .vid_req     (Vid_Req),
    .last_grant  (last_grant),
    .grant       (pick_grant),
    .grant_valid (pick_valid)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_en   = 1'b0;
    capture_en = 1'b0;
    ack_en     = 1'b0;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_UB_N  = 1'b1;
    SRAM_DQ_OE = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          latch_en = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        SRAM_CE_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_DQ_OE = rw_q;
        cnt_d      = CNT_LOAD;
        state_d    = ACCESS;
      end
      ACCESS: begin
        SRAM_CE_N  = 1'b0;
        SRAM_LB_N  = 1'b0;
        SRAM_UB_N  = 1'b0;
        SRAM_OE_N  = rw_q;
        SRAM_WE_N  = ~rw_q;
        SRAM_DQ_OE = rw_q;
        if (cnt_q == '0) begin
          capture_en = ~rw_q;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        ack_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Command is latched once in IDLE; requester inputs are ignored afterwards.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      grant_q     <= PORT_CPU;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      if (latch_en) begin
        grant_q <= pick_grant;
        if (pick_grant == PORT_VID) begin
          rw_q    <= Vid_R_W;
          addr_q  <= Vid_Addr;
          wdata_q <= Vid_WData;
        end else begin
          rw_q    <= Cpu_R_W;
          addr_q  <= Cpu_Addr;
          wdata_q <= Cpu_WData;
        end
      end
      if (capture_en) begin
        if (grant_q == PORT_VID) begin
          vid_rdata_q <= SRAM_DQ_In;
        end else begin
          cpu_rdata_q <= SRAM_DQ_In;
        end
      end
    end
  end

  assign Cpu_Ack     = ack_en & (grant_q == PORT_CPU);
  assign Vid_Ack     = ack_en & (grant_q == PORT_VID);
  assign Cpu_RData   = cpu_rdata_q;
  assign Vid_RData   = vid_rdata_q;
  assign Busy        = (state_q != IDLE);
  assign SRAM_ADDR   = {4'b0000, addr_q};
  assign SRAM_DQ_Out = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- self-checking bench for sram_arbiter.
// Instance 0 uses ACCESS_CYCLES=2 and is fully checked; instances 1 and 2
// (ACCESS_CYCLES=1 and 15) share its inputs and are used for latency only.
module tb_sram_arbiter;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR_BUILD = 1'b1;
`else
  localparam bit RR_BUILD = 1'b0;
`endif
  localparam int AC = 2;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_rw, vid_req, vid_rw;
  logic [15:0] cpu_addr, cpu_wdata, vid_addr, vid_wdata;
  logic [15:0] dq_val;
  logic [15:0] dq_in;

  logic [2:0]        cpu_ack, vid_ack, busy, ce_n, oe_n, we_n, lb_n, ub_n, dq_oe;
  logic [2:0][15:0]  cpu_rdata, vid_rdata, dq_out;
  logic [2:0][19:0]  sram_addr;

  // SRAM model: returns the stimulus word only while OE is low.
  assign dq_in = oe_n[0] ? 16'hDEAD : dq_val;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int AC_G = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
    sram_arbiter #(.ACCESS_CYCLES(AC_G)) u_dut (
      .Clk         (clk),
      .Reset       (rst),
      .Cpu_Req     (cpu_req),
      .Cpu_R_W     (cpu_rw),
      .Cpu_Addr    (cpu_addr),
      .Cpu_WData   (cpu_wdata),
      .Cpu_Ack     (cpu_ack[g]),
      .Cpu_RData   (cpu_rdata[g]),
      .Vid_Req     (vid_req),
      .Vid_R_W     (vid_rw),
      .Vid_Addr    (vid_addr),
      .Vid_WData   (vid_wdata),
      .Vid_Ack     (vid_ack[g]),
      .Vid_RData   (vid_rdata[g]),
      .Busy        (busy[g]),
      .SRAM_CE_N   (ce_n[g]),
      .SRAM_OE_N   (oe_n[g]),
      .SRAM_WE_N   (we_n[g]),
      .SRAM_LB_N   (lb_n[g]),
      .SRAM_UB_N   (ub_n[g]),
      .SRAM_ADDR   (sram_addr[g]),
      .SRAM_DQ_Out (dq_out[g]),
      .SRAM_DQ_OE  (dq_oe[g]),
      .SRAM_DQ_In  (dq_in)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        port;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        cpu_req, vid_req, cpu_rw, vid_rw;
    logic [15:0] cpu_addr, cpu_wdata, vid_addr, vid_wdata, dq;
    logic        exp_port;
    logic [15:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk_vec(input logic cr, input logic vr, input logic crw, input logic vrw,
                                  input logic [15:0] ca, input logic [15:0] cwd,
                                  input logic [15:0] va, input logic [15:0] vwd,
                                  input logic [15:0] dq, input logic ep, input logic [15:0] er);
    vec_t v;
    v.cpu_req = cr;  v.vid_req = vr;  v.cpu_rw = crw; v.vid_rw = vrw;
    v.cpu_addr = ca; v.cpu_wdata = cwd; v.vid_addr = va; v.vid_wdata = vwd;
    v.dq = dq; v.exp_port = ep; v.exp_rdata = er;
    return v;
  endfunction

  function automatic exp_t mk_exp(input logic p, input logic rw, input logic [15:0] a,
                                  input logic [15:0] wd, input logic [15:0] rd);
    exp_t e;
    e.port = p; e.rw = rw; e.addr = a; e.wdata = wd; e.rdata = rd;
    return e;
  endfunction

  // Monitor: strobe activity per transaction, compared against the popped expectation at Ack.
  int          mon_oe, mon_we, mon_dqoe;
  logic [15:0] mon_wd;
  logic [19:0] mon_addr;
  logic        mon_seen, mon_moved;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      mon_oe = 0; mon_we = 0; mon_dqoe = 0; mon_wd = '0;
      mon_addr = '0; mon_seen = 1'b0; mon_moved = 1'b0;
    end else begin
      if (!ce_n[0]) begin
        if (!oe_n[0]) mon_oe++;
        if (!we_n[0]) begin
          mon_we++;
          mon_wd = dq_out[0];
        end
        if (dq_oe[0]) mon_dqoe++;
        if (mon_seen && sram_addr[0] !== mon_addr) mon_moved = 1'b1;
        mon_addr = sram_addr[0];
        mon_seen = 1'b1;
      end
      if (cpu_ack[0] || vid_ack[0]) begin
        check("ack_exclusive", {31'd0, cpu_ack[0] & vid_ack[0]}, 32'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_ack", {30'd0, cpu_ack[0], vid_ack[0]}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("ack_port", {31'd0, vid_ack[0]}, {31'd0, e.port});
          check("addr", sram_addr[0], {16'd0, 4'h0, e.addr});
          check("addr_stable", {31'd0, mon_moved}, 32'd0);
          check("done_strobes", {26'd0, ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], dq_oe[0]},
                32'b111110);
          if (e.rw) begin
            check("we_low_cycles", mon_we, AC);
            check("oe_low_on_write", mon_oe, 0);
            check("dq_oe_cycles", mon_dqoe, AC + 1);
            check("write_data", {16'd0, mon_wd}, {16'd0, e.wdata});
          end else begin
            check("oe_low_cycles", mon_oe, AC);
            check("we_low_on_read", mon_we, 0);
            check("rdata", {16'd0, (e.port ? vid_rdata[0] : cpu_rdata[0])}, {16'd0, e.rdata});
          end
        end
        mon_oe = 0; mon_we = 0; mon_dqoe = 0; mon_wd = '0;
        mon_seen = 1'b0; mon_moved = 1'b0;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; cpu_req = 1'b0; vid_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!(cpu_ack[0] || vid_ack[0]) && n < 40);
    if (!(cpu_ack[0] || vid_ack[0])) check("ack_timeout", n, 0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ctrl"},
          {23'd0, ce_n[0], oe_n[0], we_n[0], lb_n[0], ub_n[0], dq_oe[0], busy[0], cpu_ack[0], vid_ack[0]},
          32'b1_1111_0000);
    check({tag, "_addr"}, sram_addr[0], 32'd0);
    check({tag, "_rdata"}, {cpu_rdata[0], vid_rdata[0]}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int n;
    int lat[3];
    vec_t v;

    vecs[0] = mk_vec(1, 0, 0, 0, 16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 0, 16'hBEEF);
    vecs[1] = mk_vec(0, 1, 0, 1, 16'h0000, 16'h0000, 16'h8000, 16'h1234, 16'h0000, 1, 16'h0000);
    vecs[2] = mk_vec(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h0A0A, 1, 16'h0A0A);
    vecs[3] = mk_vec(1, 0, 1, 0, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
    vecs[4] = mk_vec(1, 1, 0, 1, 16'h1111, 16'h0000, 16'h2222, 16'h3333, 16'h7777, RR_BUILD, 16'h7777);
    vecs[5] = mk_vec(1, 1, 1, 0, 16'h4444, 16'h5555, 16'h6666, 16'h0000, 16'h9999, 0, 16'h0000);
    vecs[6] = mk_vec(1, 0, 0, 0, 16'h7FFE, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 0, 16'h8001);

    cpu_rw = 0; vid_rw = 0; cpu_addr = 0; cpu_wdata = 0;
    vid_addr = 0; vid_wdata = 0; dq_val = 0;
    do_reset();
    check_reset_state("reset");

    // Table-driven single transactions.
    foreach (vecs[i]) begin
      v = vecs[i];
      cpu_rw = v.cpu_rw; cpu_addr = v.cpu_addr; cpu_wdata = v.cpu_wdata;
      vid_rw = v.vid_rw; vid_addr = v.vid_addr; vid_wdata = v.vid_wdata;
      dq_val = v.dq;
      cpu_req = v.cpu_req; vid_req = v.vid_req;
      if (v.exp_port)
        sb_q.push_back(mk_exp(1'b1, v.vid_rw, v.vid_addr, v.vid_wdata, v.exp_rdata));
      else
        sb_q.push_back(mk_exp(1'b0, v.cpu_rw, v.cpu_addr, v.cpu_wdata, v.exp_rdata));
      wait_ack(n);
      check("latency", n, AC + 2);
      cpu_req = 1'b0; vid_req = 1'b0;
      @(negedge clk);
    end

    // Request dropped during SETUP still completes.
    cpu_rw = 1'b0; cpu_addr = 16'h0ABC; dq_val = 16'h4242; cpu_req = 1'b1;
    sb_q.push_back(mk_exp(1'b0, 1'b0, 16'h0ABC, 16'h0000, 16'h4242));
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    wait_ack(n);
    check("drop_latency", n, AC + 1);
    @(negedge clk);

    // Reset in the second ACCESS cycle of a write aborts without Ack.
    vid_rw = 1'b1; vid_addr = 16'h0777; vid_wdata = 16'hAAAA; vid_req = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_in_access", {31'd0, we_n[0]}, 32'd0);
    rst = 1'b1; vid_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // Both ports hold requests continuously.
    do_reset();
    cpu_rw = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hC0C0;
    vid_rw = 1'b1; vid_addr = 16'h0200; vid_wdata = 16'h5A5A;
    cpu_req = 1'b1; vid_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (RR_BUILD && (k % 2 == 1))
        sb_q.push_back(mk_exp(1'b1, 1'b1, 16'h0200, 16'h5A5A, 16'h0000));
      else
        sb_q.push_back(mk_exp(1'b0, 1'b1, 16'h0100, 16'hC0C0, 16'h0000));
    end
    for (int k = 0; k < 4; k++) begin
      wait_ack(n);
      check("stream_spacing", n, (k == 0) ? AC + 2 : AC + 3);
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    @(negedge clk);

    // Latency across ACCESS_CYCLES = 2, 1, 15.
    do_reset();
    cpu_rw = 1'b0; cpu_addr = 16'h0055; dq_val = 16'h6161; cpu_req = 1'b1;
    sb_q.push_back(mk_exp(1'b0, 1'b0, 16'h0055, 16'h0000, 16'h6161));
    lat = '{0, 0, 0};
    for (int t = 1; t <= 40; t++) begin
      @(posedge clk);
      @(negedge clk);
      if (t == 1) cpu_req = 1'b0;
      for (int i = 0; i < 3; i++)
        if (cpu_ack[i] && lat[i] == 0) lat[i] = t;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    check("latency_ac2", lat[0], 4);
    check("latency_ac1", lat[1], 3);
    check("latency_ac15", lat[2], 17);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter: ACCESS_CYCLES, 2, number of cycles the read/write strobe stays asserted (legal 1..15).
REQ-002 SHALL have ports (clock and reset first):
- Clk  input  1  system clock; all logic on rising edge; one clock; reset is synchronous and active-high.
- Reset  input  1  synchronous active-high reset.
- Cpu_Req  input  1  CPU access request; held until Cpu_Ack.
- Cpu_R_W  input  1  1=write, 0=read.
- Cpu_Addr  input  16  CPU word address.
- Cpu_WData  input  16  CPU write data.
- Cpu_Ack  output  1  one-cycle completion pulse.
- Cpu_RData  output  16  read data, valid while Cpu_Ack=1, held until next CPU read.
- Vid_Req, Vid_R_W, Vid_Addr[16], Vid_WData[16]  input  video/DMA requester; same meaning as CPU.
- Vid_Ack  output  1; Vid_RData  output  16; same meaning as CPU.
- Busy  output  1  1 when state != IDLE.
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_LB_N, SRAM_UB_N  output  1 each  active-low SRAM strobes.
- SRAM_ADDR  output  20  {4'b0000, granted address}.
- SRAM_DQ_Out  output  16  write data to top-level tri-state.
- SRAM_DQ_OE  output  1  1 = drive SRAM_DQ.
- SRAM_DQ_In  input  16  data returned from SRAM.

Function
REQ-003 SHALL implement FSM states IDLE, SETUP, ACCESS, DONE.
REQ-004 IDLE: if any Req=1, latch grant, R_W, Addr, WData of the winner, go to SETUP; else stay.
REQ-005 Requests SHALL be sampled only in IDLE; requester inputs ignored at all other times.
REQ-006 SETUP (1 cycle): SRAM_CE_N=0, LB_N=UB_N=0, SRAM_ADDR valid, OE_N=WE_N=1; SRAM_DQ_OE=1 if write.
REQ-007 ACCESS (ACCESS_CYCLES cycles, down-counter): CE_N=0; read: OE_N=0; write: WE_N=0, SRAM_DQ_OE=1, SRAM_DQ_Out=latched WData.
REQ-008 Read data SHALL be captured from SRAM_DQ_In on the last ACCESS cycle into the granted port's RData register.
REQ-009 DONE (1 cycle): all strobes high, SRAM_DQ_OE=0, granted port's Ack=1; next state IDLE.
REQ-010 Latency: Ack asserted exactly ACCESS_CYCLES+2 cycles after the IDLE cycle that sampled Req (4 cycles at default).
REQ-011 Address and write data SHALL stay stable from SETUP through DONE.
REQ-012 Both Req=1 in IDLE: fixed priority, CPU wins (see REQ-017 for alternative).
REQ-013 Req dropped mid-transaction: transaction SHALL complete and Ack SHALL still pulse.
REQ-014 Requester holding Req after Ack SHALL be regranted in the following IDLE cycle (minimum 1 idle cycle between transactions).
REQ-015 Exactly one of Cpu_Ack/Vid_Ack SHALL be high in any cycle, or neither.

Reset
REQ-016 On Reset=1 at a clock edge, including mid-transaction: state=IDLE, counter=0, all SRAM_*_N=1, SRAM_DQ_OE=0, SRAM_ADDR=0, Acks=0, RData=0, Busy=0, round-robin pointer=Video (CPU first); aborted transaction produces no Ack.

Configuration
REQ-017 With SRAM_ARB_RR_EN defined: simultaneous requests SHALL alternate, granting the port not granted last; pointer updates on each grant. Without it: fixed CPU priority, no pointer register.

Structure
REQ-018 Shared package elc3_mem_pkg SHALL hold the state enum, port-index constants (PORT_CPU=0, PORT_VID=1) and the ACCESS_CYCLES default.
REQ-019 Grant selection SHALL be one combinational sub-module arb_picker (inputs: two requests, pointer; output: grant index, valid).

Verification
REQ-020 CPU read 0x3000, SRAM_DQ_In=0xBEEF -> Cpu_Ack 4 cycles after sampling, Cpu_RData=0xBEEF, OE_N low 2 cycles, WE_N never low.
REQ-021 Video write 0x8000 data 0x1234 -> SRAM_ADDR=0x08000, WE_N low 2 cycles, SRAM_DQ_OE=1 SETUP..ACCESS, Vid_Ack pulse.
REQ-022 Both request continuously: fixed build -> CPU every grant; SRAM_ARB_RR_EN build -> CPU, Vid, CPU, Vid.
REQ-023 Reset asserted in 2nd ACCESS cycle -> next edge strobes all 1, DQ_OE=0, no Ack, Busy=0.
REQ-024 ACCESS_CYCLES=1 and 15 -> Ack latency 3 and 17 cycles respectively.
